// File: rtl/mmio_responder.sv
// mmio_responder: MMIO bank behind the data-memory port (64-bit machine timer, msip, console TX FIFO).
// Latency: loads answer exactly one cycle after presentation; stores take effect at the next edge.
// Backpressure: none on loads/stores; TX bytes drain on valid/ready, pushes into a full FIFO drop unless a pop frees a slot.

// fifo_sync: generic single-clock FIFO with occupancy count and registered storage.
// Latency: a push is visible at the head one cycle later (no write-to-read bypass).
// Backpressure: a push while full is accepted only if the head is popped in the same cycle, otherwise dropped.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_vld,
    input  logic [WIDTH-1:0]        i_wr_dat,
    input  logic                    i_rd_rdy,
    output logic                    o_rd_vld,
    output logic [WIDTH-1:0]        o_rd_dat,
    output logic                    o_full,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;

    assign w_empty  = (r_count == '0);
    assign o_full   = (r_count == FULL_CNT);
    assign w_pop    = !w_empty && i_rd_rdy;
    assign w_push   = i_wr_vld && (!o_full || w_pop);
    assign o_rd_vld = !w_empty;
    assign o_rd_dat = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count  = r_count;

    // Pointers wrap naturally at DEPTH; count tracks net push/pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Storage write; contents need no reset since the head is masked while empty.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
    end
endmodule

module mmio_responder #(
    parameter int          XLEN          = 32,
    parameter logic [31:0] MMIO_BASE     = 32'h4000_0000,
    parameter int          TX_FIFO_DEPTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_data_mem_addr,
    input  logic [XLEN-1:0] i_data_mem_wr_data,
    input  logic [3:0]      i_data_mem_per_byte_wr_en,
    input  logic [XLEN-1:0] i_mmio_load_addr,
    input  logic            i_mmio_load_valid,
    output logic [XLEN-1:0] o_mmio_read_data,
    output logic            o_mmio_read_valid,
    output logic [7:0]      o_tx_data,
    output logic            o_tx_valid,
    input  logic            i_tx_ready,
    output logic            o_timer_irq,
    output logic            o_soft_irq
);
    localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

    localparam logic [5:0] OFF_TX_DATA   = 6'h00;
    localparam logic [5:0] OFF_TX_STATUS = 6'h01;
    localparam logic [5:0] OFF_MSIP      = 6'h02;
    localparam logic [5:0] OFF_MTIME_LO  = 6'h04;
    localparam logic [5:0] OFF_MTIME_HI  = 6'h05;
    localparam logic [5:0] OFF_CMP_LO    = 6'h06;
    localparam logic [5:0] OFF_CMP_HI    = 6'h07;

    logic [63:0]     r_mtime;
    logic [63:0]     r_mtimecmp;
    logic [31:0]     r_shadow;
    logic            r_msip;
    logic            r_timer_irq;
    logic            r_read_valid;
    logic [XLEN-1:0] r_read_data;

    logic [63:0]     w_mtime_nxt;
    logic [XLEN-1:0] w_read_data;
    logic            w_st_act;
    logic            w_ld_hit;
    logic [5:0]      w_st_off;
    logic [5:0]      w_ld_off;
    logic            w_wr_tx;
    logic            w_wr_msip;
    logic            w_wr_mtime_lo;
    logic            w_wr_mtime_hi;
    logic            w_wr_cmp_lo;
    logic            w_wr_cmp_hi;
    logic            w_tx_full;
    logic [CW-1:0]   w_tx_count;
    logic [31:0]     w_tx_status;
    logic            w_unused;

    // Each enabled byte lane of dat replaces the matching lane of old.
    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] dat,
                                               input logic [3:0] be);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) v[8*b +: 8] = dat[8*b +: 8];
        end
        return v;
    endfunction

    assign w_st_off      = i_data_mem_addr[7:2];
    assign w_ld_off      = i_mmio_load_addr[7:2];
    assign w_st_act      = (i_data_mem_addr[31:8] == MMIO_BASE[31:8]) && (|i_data_mem_per_byte_wr_en);
    assign w_ld_hit      = (i_mmio_load_addr[31:8] == MMIO_BASE[31:8]);
    assign w_wr_tx       = w_st_act && (w_st_off == OFF_TX_DATA) && i_data_mem_per_byte_wr_en[0];
    assign w_wr_msip     = w_st_act && (w_st_off == OFF_MSIP);
    assign w_wr_mtime_lo = w_st_act && (w_st_off == OFF_MTIME_LO);
    assign w_wr_mtime_hi = w_st_act && (w_st_off == OFF_MTIME_HI);
    assign w_wr_cmp_lo   = w_st_act && (w_st_off == OFF_CMP_LO);
    assign w_wr_cmp_hi   = w_st_act && (w_st_off == OFF_CMP_HI);
    assign w_unused      = ^{i_data_mem_addr[1:0], i_mmio_load_addr[1:0]};

    fifo_sync #(
        .WIDTH (8),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wr_vld (w_wr_tx),
        .i_wr_dat (i_data_mem_wr_data[7:0]),
        .i_rd_rdy (i_tx_ready),
        .o_rd_vld (o_tx_valid),
        .o_rd_dat (o_tx_data),
        .o_full   (w_tx_full),
        .o_count  (w_tx_count)
    );

    assign w_tx_status = {16'h0, 8'(w_tx_count), 6'h0, !o_tx_valid, w_tx_full};

    // Software writes to mtime replace the increment for that cycle.
    always_comb begin
        w_mtime_nxt = r_mtime + 64'd1;
        if (w_wr_mtime_lo)
            w_mtime_nxt = {r_mtime[63:32], byte_merge(r_mtime[31:0], i_data_mem_wr_data, i_data_mem_per_byte_wr_en)};
        else if (w_wr_mtime_hi)
            w_mtime_nxt = {byte_merge(r_mtime[63:32], i_data_mem_wr_data, i_data_mem_per_byte_wr_en), r_mtime[31:0]};
    end

    // Load data comes from pre-update register state; misses and unmapped offsets read 0.
    always_comb begin
        w_read_data = '0;
        if (i_mmio_load_valid && w_ld_hit) begin
            case (w_ld_off)
                OFF_TX_STATUS: w_read_data = w_tx_status;
                OFF_MSIP:      w_read_data = {31'h0, r_msip};
                OFF_MTIME_LO:  w_read_data = r_mtime[31:0];
                OFF_MTIME_HI:  w_read_data = r_shadow;
                OFF_CMP_LO:    w_read_data = r_mtimecmp[31:0];
                OFF_CMP_HI:    w_read_data = r_mtimecmp[63:32];
                default:       w_read_data = '0;
            endcase
        end
    end

    // Register bank, timer compare and the one-cycle load response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mtime      <= '0;
            r_mtimecmp   <= '1;
            r_shadow     <= '0;
            r_msip       <= 1'b0;
            r_timer_irq  <= 1'b0;
            r_read_valid <= 1'b0;
            r_read_data  <= '0;
        end else begin
            r_mtime      <= w_mtime_nxt;
            r_timer_irq  <= (r_mtime >= r_mtimecmp);
            r_read_valid <= i_mmio_load_valid;
            r_read_data  <= w_read_data;
            if (i_mmio_load_valid && w_ld_hit && (w_ld_off == OFF_MTIME_LO))
                r_shadow <= r_mtime[63:32];
            if (w_wr_msip) begin
                r_msip <= i_data_mem_per_byte_wr_en[0] ? i_data_mem_wr_data[0] : r_msip;
            end
            if (w_wr_cmp_lo)
                r_mtimecmp[31:0] <= byte_merge(r_mtimecmp[31:0], i_data_mem_wr_data, i_data_mem_per_byte_wr_en);
            if (w_wr_cmp_hi)
                r_mtimecmp[63:32] <= byte_merge(r_mtimecmp[63:32], i_data_mem_wr_data, i_data_mem_per_byte_wr_en);
        end
    end

    assign o_mmio_read_data  = r_read_data;
    assign o_mmio_read_valid = r_read_valid;
    assign o_timer_irq       = r_timer_irq;
    assign o_soft_irq        = r_msip;
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed stimulus for mmio_responder with a transaction-level reference model.
// Latency: the model predicts every registered output one edge after the inputs it sees.
// Backpressure: the TX consumer ready is driven directly by the stimulus.
module tb_mmio_responder;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] st_addr;
    logic [31:0] st_dat;
    logic [3:0]  st_be;
    logic [31:0] ld_addr;
    logic        ld_vld;
    logic        tx_rdy;
    logic [31:0] rd_dat;
    logic        rd_vld;
    logic [7:0]  tx_dat;
    logic        tx_vld;
    logic        timer_irq;
    logic        soft_irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmio_responder #(
        .XLEN          (32),
        .MMIO_BASE     (BASE),
        .TX_FIFO_DEPTH (8)
    ) dut (
        .i_clk                     (clk),
        .i_rst                     (rst),
        .i_data_mem_addr           (st_addr),
        .i_data_mem_wr_data        (st_dat),
        .i_data_mem_per_byte_wr_en (st_be),
        .i_mmio_load_addr          (ld_addr),
        .i_mmio_load_valid         (ld_vld),
        .o_mmio_read_data          (rd_dat),
        .o_mmio_read_valid         (rd_vld),
        .o_tx_data                 (tx_dat),
        .o_tx_valid                (tx_vld),
        .i_tx_ready                (tx_rdy),
        .o_timer_irq               (timer_irq),
        .o_soft_irq                (soft_irq)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint unsigned m_mtime;
    longint unsigned m_cmp;
    logic [31:0]     m_shadow;
    logic            m_msip;
    byte unsigned    m_q[$];
    logic            m_rvld;
    logic [31:0]     m_rdat;
    logic            m_irq;
    bit              m_live = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] v;
        v = o;
        for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if ((a & 32'hFFFF_FF00) != BASE) return 32'h0;
        case (a[7:0] & 8'hFC)
            8'h04:   return {16'h0, 8'(m_q.size()), 6'h0, m_q.size() == 0, m_q.size() == 8};
            8'h08:   return {31'h0, m_msip};
            8'h10:   return m_mtime[31:0];
            8'h14:   return m_shadow;
            8'h18:   return m_cmp[31:0];
            8'h1C:   return m_cmp[63:32];
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [31:0] sa, sd, la, t;
        logic [3:0]  sbe;
        logic        lv, rdy, pop, push, st_hit, wrote;
        sa = st_addr; sd = st_dat; sbe = st_be; la = ld_addr; lv = ld_vld; rdy = tx_rdy;
        if (rst) begin
            m_live = 1'b1;
            m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_shadow = 32'h0; m_msip = 1'b0;
            m_q.delete(); m_rvld = 1'b0; m_rdat = 32'h0; m_irq = 1'b0;
        end else begin
            m_rvld = lv;
            m_rdat = lv ? m_read(la) : 32'h0;
            if (lv && ((la & 32'hFFFF_FFFC) == (BASE | 32'h10))) m_shadow = m_mtime[63:32];
            m_irq  = (m_mtime >= m_cmp);
            st_hit = ((sa & 32'hFFFF_FF00) == BASE) && (sbe != 4'h0);
            pop    = (m_q.size() > 0) && rdy;
            push   = st_hit && ((sa[7:0] & 8'hFC) == 8'h00) && sbe[0];
            if (push && m_q.size() == 8 && !pop) push = 1'b0;
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(sd[7:0]);
            wrote = 1'b0;
            if (st_hit) begin
                case (sa[7:0] & 8'hFC)
                    8'h08: begin t = merge({31'h0, m_msip}, sd, sbe); m_msip = t[0]; end
                    8'h10: begin m_mtime = {m_mtime[63:32], merge(m_mtime[31:0], sd, sbe)}; wrote = 1'b1; end
                    8'h14: begin m_mtime = {merge(m_mtime[63:32], sd, sbe), m_mtime[31:0]}; wrote = 1'b1; end
                    8'h18: m_cmp = {m_cmp[63:32], merge(m_cmp[31:0], sd, sbe)};
                    8'h1C: m_cmp = {merge(m_cmp[63:32], sd, sbe), m_cmp[31:0]};
                    default: ;
                endcase
            end
            if (!wrote) m_mtime = m_mtime + 64'd1;
        end
        #1;
        if (m_live) begin
            check("rd_vld", 32'(rd_vld), 32'(m_rvld));
            if (m_rvld) check("rd_dat", rd_dat, m_rdat);
            check("timer_irq", 32'(timer_irq), 32'(m_irq));
            check("soft_irq", 32'(soft_irq), 32'(m_msip));
            check("tx_vld", 32'(tx_vld), 32'(m_q.size() > 0));
            if (m_q.size() > 0) check("tx_dat", 32'(tx_dat), 32'(m_q[0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_addr = a; st_dat = d; st_be = be;
        cyc();
        st_be = 4'h0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] exp, input string nm);
        ld_addr = a; ld_vld = 1'b1;
        cyc();
        ld_vld = 1'b0;
        check({nm, "_vld"}, 32'(rd_vld), 32'h1);
        check(nm, rd_dat, exp);
    endtask

    initial begin
        int k;
        byte unsigned exp_tx [8] = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h4A};
        rst = 1'b1; st_addr = 32'h0; st_dat = 32'h0; st_be = 4'h0;
        ld_addr = 32'h0; ld_vld = 1'b0; tx_rdy = 1'b0;
        cyc(); cyc();
        check("reset_rd_vld", 32'(rd_vld), 32'h0);
        check("reset_rd_dat", rd_dat, 32'h0);
        check("reset_tx_vld", 32'(tx_vld), 32'h0);
        check("reset_tx_dat", 32'(tx_dat), 32'h0);
        check("reset_timer_irq", 32'(timer_irq), 32'h0);
        check("reset_soft_irq", 32'(soft_irq), 32'h0);
        rst = 1'b0;
        cyc();

        // Timer readback, LO then HI back-to-back.
        ld(BASE + 32'h10, 32'h1, "mtime_lo_first");
        ld(BASE + 32'h14, 32'h0, "mtime_hi_first");

        // Compare at 0x20: irq first seen while mtime already reads 0x21.
        st(BASE + 32'h18, 32'h0000_0020, 4'hF);
        st(BASE + 32'h1C, 32'h0, 4'hF);
        k = 0;
        while (timer_irq !== 1'b1 && k < 200) begin cyc(); k++; end
        check("timer_irq_rise", 32'(timer_irq), 32'h1);
        ld(BASE + 32'h10, 32'h21, "mtime_at_irq");

        // Carry from LO into HI.
        st(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
        st(BASE + 32'h14, 32'h0, 4'hF);
        cyc();
        ld(BASE + 32'h10, 32'h0, "carry_lo");
        ld(BASE + 32'h14, 32'h1, "carry_hi");

        // Fill the console FIFO; ninth byte is dropped.
        for (int i = 0; i < 9; i++) st(BASE, 32'h41 + 32'(i), 4'h1);
        ld(BASE + 32'h04, 32'h0000_0801, "tx_status_full");
        ld(BASE, 32'h0, "tx_data_read");
        check("tx_head_first", 32'(tx_dat), 32'h41);

        // Push and pop together while full.
        st_addr = BASE; st_dat = 32'h4A; st_be = 4'h1; tx_rdy = 1'b1;
        cyc();
        st_be = 4'h0; tx_rdy = 1'b0;
        ld(BASE + 32'h04, 32'h0000_0801, "tx_status_pushpop");
        tx_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_vld", 32'(tx_vld), 32'h1);
            check("drain_dat", 32'(tx_dat), 32'(exp_tx[i]));
            cyc();
        end
        tx_rdy = 1'b0;
        check("drain_empty", 32'(tx_vld), 32'h0);

        // Partial-byte store into a freshly reset compare register.
        rst = 1'b1; cyc(); rst = 1'b0;
        st(BASE + 32'h18, 32'h0000_AB00, 4'b0010);
        ld(BASE + 32'h18, 32'hFFFF_ABFF, "cmp_lo_byte1");

        // msip, out-of-window store and load.
        st(BASE + 32'h08, 32'h1, 4'hF);
        check("soft_irq_set", 32'(soft_irq), 32'h1);
        st(32'h5000_0008, 32'h0, 4'hF);
        check("soft_irq_miss", 32'(soft_irq), 32'h1);
        ld(32'h5000_0010, 32'h0, "miss_load");

        // Load and store to msip in one cycle: load sees the old value.
        st_addr = BASE + 32'h08; st_dat = 32'h0; st_be = 4'hF;
        ld_addr = BASE + 32'h08; ld_vld = 1'b1;
        cyc();
        st_be = 4'h0; ld_vld = 1'b0;
        check("same_cycle_ld", rd_dat, 32'h1);
        check("soft_irq_clear", 32'(soft_irq), 32'h0);

        // Reset discards a pending response.
        ld_addr = BASE + 32'h10; ld_vld = 1'b1;
        cyc();
        ld_vld = 1'b0; rst = 1'b1;
        cyc();
        check("rst_kills_rsp", 32'(rd_vld), 32'h0);
        rst = 1'b0;
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
